// File: rtl/hc595_serial_driver_pkg.sv
// ----------------------------------------------------------------------------
// hc595_serial_driver_pkg
//   Shared definitions for the 74HC595 serial display driver:
//   - default frame width and shift-clock divider
//   - FSM state encoding (2 bits)
// ----------------------------------------------------------------------------
package hc595_serial_driver_pkg;

    // Two cascaded 595s: {dp, seg[6:0], sel[7:0]}
    localparam int DATA_W_DEF = 16;
    // System-clock cycles per half shift-clock period
    localparam int DIV_DEF    = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LATCH    = 2'd3
    } state_t;

endpackage

// File: rtl/hc595_serial_driver_if.sv
// ----------------------------------------------------------------------------
// hc595_serial_driver_if
//   Connection between the display scan generator and the 595 pin driver.
//   data  : word to shift out (sampled at frame start)
//   s_en  : enable, a frame starts when high while the driver is idle
//   sh_cp : 595 shift clock
//   st_cp : 595 storage (latch) clock
//   ds    : 595 serial data, MSB first
//   master : scan-generator side (drives data/s_en)
//   slave  : driver side (drives the pin signals)
// ----------------------------------------------------------------------------
interface hc595_serial_driver_if
    import hc595_serial_driver_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic [DATA_W-1:0] data;
    logic              s_en;
    logic              sh_cp;
    logic              st_cp;
    logic              ds;

    modport master (
        output data, s_en,
        input  sh_cp, st_cp, ds
    );

    modport slave (
        input  data, s_en,
        output sh_cp, st_cp, ds
    );

endinterface

// File: rtl/hc595_serial_driver.sv
// ----------------------------------------------------------------------------
// hc595_serial_driver
//   Serialises a DATA_W-bit word into daisy-chained 74HC595 shift registers.
//   Each frame: DATA_W shift-clock periods (2*DIV system cycles each) with ds
//   set up during the low half, then one DIV-cycle storage-clock pulse.
//   Frame length is 1 + 2*DIV*DATA_W + DIV system cycles.
//
//   Ports
//     clk     : system clock, rising edge
//     reset_n : synchronous reset, ACTIVE HIGH (historical name kept)
//     bus     : slave side of hc595_serial_driver_if (data, s_en in;
//               sh_cp, st_cp, ds out - all outputs registered)
// ----------------------------------------------------------------------------
module hc595_serial_driver
    import hc595_serial_driver_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DIV    = DIV_DEF
)(
    input  logic                   clk,
    input  logic                   reset_n,
    hc595_serial_driver_if.slave   bus
);

    localparam int PW = $clog2(DIV) + 1;
    localparam int CW = $clog2(DATA_W);

    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [CW-1:0] BIT_LAST   = CW'(DATA_W - 1);

    state_t            state;
    state_t            state_nx;
    logic [PW-1:0]     presc;
    logic [CW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              presc_done;

    logic              sh_cp_q, sh_cp_nx;
    logic              st_cp_q, st_cp_nx;
    logic              ds_q,    ds_nx;

    assign presc_done = (presc == PRESC_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: the default assignment first keeps this purely combinational;
    // any path that leaves state_nx unassigned would infer a latch.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:     if (bus.s_en) state_nx = SHIFT_LO;
            SHIFT_LO: if (presc_done) state_nx = SHIFT_HI;
            SHIFT_HI: if (presc_done) state_nx = (bit_cnt == BIT_LAST) ? LATCH : SHIFT_LO;
            LATCH:    if (presc_done) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: computed from the upcoming state so the registered
    // pins line up exactly with the state they belong to.
    // ds only moves on entry to SHIFT_LO, a full half period before the
    // next sh_cp rising edge.
    // ------------------------------------------------------------------
    always_comb begin
        sh_cp_nx = (state_nx == SHIFT_HI);
        st_cp_nx = (state_nx == LATCH);
        ds_nx    = ds_q;
        if (state == IDLE && state_nx == SHIFT_LO) begin
            ds_nx = bus.data[DATA_W-1];
        end else if (state == SHIFT_HI && state_nx == SHIFT_LO) begin
            ds_nx = shreg[DATA_W-2];
        end
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset_n) begin
            presc   <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            sh_cp_q <= 1'b0;
            st_cp_q <= 1'b0;
            ds_q    <= 1'b0;
        end else begin
            sh_cp_q <= sh_cp_nx;
            st_cp_q <= st_cp_nx;
            ds_q    <= ds_nx;

            // Prescaler restarts on every state change and is parked in IDLE.
            if (state_nx != state || state == IDLE) begin
                presc <= '0;
            end else begin
                presc <= presc + 1'b1;
            end

            if (state == IDLE && bus.s_en) begin
                shreg   <= bus.data;
                bit_cnt <= '0;
            end else if (state == SHIFT_HI && presc_done && bit_cnt != BIT_LAST) begin
                shreg   <= shreg << 1;
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    assign bus.sh_cp = sh_cp_q;
    assign bus.st_cp = st_cp_q;
    assign bus.ds    = ds_q;

endmodule

// File: tb/tb_hc595_serial_driver.sv
// ----------------------------------------------------------------------------
// tb_hc595_serial_driver
//   Two drivers (DIV=4 and DIV=1) share the same data/s_en/reset stimulus.
//   A frame-level model decides, from frame-length arithmetic, when each
//   driver accepts a word and queues {word, start cycle}. A negedge monitor
//   reassembles each frame from ds at sh_cp rising edges and checks it,
//   plus edge timing and latch pulse width, when st_cp rises/falls.
// ----------------------------------------------------------------------------
module tb_hc595_serial_driver;

    localparam int W     = 16;
    localparam int NDUT  = 2;
    localparam int DIV_A = hc595_serial_driver_pkg::DIV_DEF;
    localparam int DIV_B = 1;

    function automatic int div_of(input int k);
        return (k == 0) ? DIV_A : DIV_B;
    endfunction

    function automatic int frame_len(input int k);
        return 1 + 2 * div_of(k) * W + div_of(k);
    endfunction

    logic         clk     = 1'b0;
    logic         reset_n = 1'b1;
    logic         s_en    = 1'b0;
    logic [W-1:0] data    = '0;

    always #5 clk = ~clk;

    hc595_serial_driver_if #(.DATA_W(W)) bus_a ();
    hc595_serial_driver_if #(.DATA_W(W)) bus_b ();

    assign bus_a.data = data;
    assign bus_a.s_en = s_en;
    assign bus_b.data = data;
    assign bus_b.s_en = s_en;

    hc595_serial_driver #(.DATA_W(W), .DIV(DIV_A)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_a)
    );

    hc595_serial_driver #(.DATA_W(W), .DIV(DIV_B)) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_b)
    );

    logic sh_v [NDUT];
    logic st_v [NDUT];
    logic ds_v [NDUT];

    assign sh_v[0] = bus_a.sh_cp;
    assign st_v[0] = bus_a.st_cp;
    assign ds_v[0] = bus_a.ds;
    assign sh_v[1] = bus_b.sh_cp;
    assign st_v[1] = bus_b.st_cp;
    assign ds_v[1] = bus_b.ds;

    // ------------------------------------------------------------------
    // Reference model: frame acceptance by arithmetic on frame length
    // ------------------------------------------------------------------
    typedef struct {
        logic [W-1:0] word;
        int           start;   // first cycle after the accepting edge
    } exp_t;

    exp_t exp_q [NDUT][$];
    int   cyc = 0;
    logic rst_seen = 1'b1;
    int   busy_until [NDUT];

    always @(posedge clk) begin
        exp_t e;
        cyc++;
        rst_seen = reset_n;
        for (int k = 0; k < NDUT; k++) begin
            if (reset_n) begin
                // A frame whose latch pulse has not appeared yet is aborted.
                if (exp_q[k].size() > 0 &&
                    cyc <= exp_q[k][exp_q[k].size()-1].start + 2 * div_of(k) * W) begin
                    void'(exp_q[k].pop_back());
                end
                busy_until[k] = cyc + 1;
            end else if (s_en && cyc >= busy_until[k]) begin
                e.word  = data;
                e.start = cyc;
                exp_q[k].push_back(e);
                busy_until[k] = cyc + frame_len(k);
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    int vectors    = 0;
    int miscompares = 0;
    logic end_req  = 1'b0;
    logic mon_done = 1'b0;

    task automatic check(input string name, input int k,
                         input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s dut%0d cycle %0d: got %0h, expected %0h",
                     name, k, cyc, actual, expected);
        end
    endtask

    logic         prev_sh [NDUT];
    logic         prev_st [NDUT];
    logic         prev_ds [NDUT];
    logic [W-1:0] bits [NDUT];
    int           nbits [NDUT];
    int           pulse_start [NDUT];

    always @(negedge clk) begin
        exp_t e;
        int   dv;
        for (int k = 0; k < NDUT; k++) begin
            dv = div_of(k);
            if (rst_seen) begin
                check("reset_outputs", k, {29'd0, sh_v[k], st_v[k], ds_v[k]}, 32'd0);
                bits[k]    = '0;
                nbits[k]   = 0;
                prev_sh[k] = 1'b0;
                prev_st[k] = 1'b0;
                prev_ds[k] = 1'b0;
            end else begin
                if (sh_v[k] && !prev_sh[k]) begin
                    check("ds_stable_at_rise", k, {31'd0, ds_v[k]}, {31'd0, prev_ds[k]});
                    check("shift_pending", k, {31'd0, exp_q[k].size() > 0}, 32'd1);
                    if (exp_q[k].size() > 0)
                        check("rise_time", k, cyc, exp_q[k][0].start + dv + 2 * dv * nbits[k]);
                    bits[k] = {bits[k][W-2:0], ds_v[k]};
                    nbits[k]++;
                end
                if (st_v[k] && !prev_st[k]) begin
                    check("latch_pending", k, {31'd0, exp_q[k].size() > 0}, 32'd1);
                    check("bit_count", k, nbits[k], W);
                    check("sh_low_in_latch", k, {31'd0, sh_v[k]}, 32'd0);
                    if (exp_q[k].size() > 0) begin
                        e = exp_q[k].pop_front();
                        check("frame_data", k, {16'd0, bits[k]}, {16'd0, e.word});
                        check("latch_time", k, cyc, e.start + 2 * dv * W);
                    end
                    pulse_start[k] = cyc;
                    bits[k]  = '0;
                    nbits[k] = 0;
                end
                if (!st_v[k] && prev_st[k])
                    check("latch_width", k, cyc - pulse_start[k], dv);
                prev_sh[k] = sh_v[k];
                prev_st[k] = st_v[k];
                prev_ds[k] = ds_v[k];
            end
        end
        if (end_req && !mon_done) begin
            for (int k = 0; k < NDUT; k++)
                check("queue_drained", k, exp_q[k].size(), 0);
            mon_done = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus (driven on negedge)
    // ------------------------------------------------------------------
    initial begin
        // Reset for 3 cycles with s_en high, then frames run back to back.
        reset_n = 1'b1;
        s_en    = 1'b1;
        data    = W'($urandom);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        repeat (300) @(negedge clk);

        // Single frame A5F0 from a one-cycle enable pulse.
        s_en = 1'b0;
        repeat (150) @(negedge clk);
        data = 16'hA5F0;
        s_en = 1'b1;
        @(negedge clk);
        s_en = 1'b0;
        data = W'($urandom);
        repeat (150) @(negedge clk);

        // Continuous enable, data changed mid-frame.
        data = 16'h8001;
        s_en = 1'b1;
        repeat (60) @(negedge clk);
        data = 16'h7FFE;
        repeat (280) @(negedge clk);
        s_en = 1'b0;
        repeat (150) @(negedge clk);

        // Enable dropped after the 5th bit of the DIV=4 driver.
        data = W'($urandom);
        s_en = 1'b1;
        repeat (1 + 2 * DIV_A * 5) @(negedge clk);
        s_en = 1'b0;
        repeat (150) @(negedge clk);

        // Reset during bit 9 of the DIV=4 driver.
        data = W'($urandom);
        s_en = 1'b1;
        @(negedge clk);
        s_en = 1'b0;
        repeat (2 * DIV_A * 8 + 2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        reset_n = 1'b0;
        repeat (150) @(negedge clk);

        // Randomised enable, data and occasional reset.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(99) < 3)  s_en = ~s_en;
            if ($urandom_range(99) < 15) data = W'($urandom);
            reset_n = ($urandom_range(999) < 2);
            @(negedge clk);
        end
        reset_n = 1'b0;
        s_en    = 1'b0;
        repeat (200) @(negedge clk);

        end_req = 1'b1;
        for (int i = 0; i < 10 && !mon_done; i++) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
